// File: rtl/uart_tx.sv
// uart_tx: byte FIFO plus serialiser for the RS-422 transmit link.
// Each byte goes out as a 12-bit frame: start, 8 data bits LSB first,
// odd parity, then 2 stop bits. Bit timing comes from an external baud
// generator that this block enables with bps_en and that answers with bps_clk.
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   bps_en      baud generator enable, high for the whole frame
//   bps_clk     one-cycle pulse at the end of each bit period
//   tx_data     byte to queue, written when tx_valid && tx_ready
//   tx_valid    tx_data is valid
//   tx_ready    FIFO has room (count < FIFO_DEPTH)
//   rs422_tx    serial line, idles high
//   busy        frame in flight or bytes queued (combinational)
//   done        one-cycle pulse when a frame's last stop bit ends
module uart_tx #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       bps_en,
  input  logic       bps_clk,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       rs422_tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned FRAME_W = 12;
  localparam int unsigned IDX_W   = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_W - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;
  logic                push, pop;
  logic [7:0]          head;
  logic [FRAME_W-1:0]  frame;
  // Holds frame bits [11:1]; bit 0 (start) goes straight onto the line.
  logic [FRAME_W-2:0]  shift_q, shift_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                line_q, line_d;
  logic                bps_en_q, bps_en_d;
  logic                done_q, done_d;

  assign tx_ready = (count < CNT_W'(FIFO_DEPTH));
  assign push     = tx_valid & tx_ready;
  assign pop      = (state_q == IDLE) && (count != '0);
  assign busy     = (state_q == SEND) || (count != '0);
  assign head     = mem[rd_ptr];
  assign frame    = {2'b11, ~^head, head, 1'b0};

  assign rs422_tx = line_q;
  assign bps_en   = bps_en_q;
  assign done     = done_q;

  // FIFO storage, no reset needed: count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // FIFO pointers and occupancy; pointers wrap since depth is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '1;
      idx_q    <= '0;
      line_q   <= 1'b1;
      bps_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      line_q   <= line_d;
      bps_en_q <= bps_en_d;
      done_q   <= done_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    line_d   = line_q;
    bps_en_d = bps_en_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        line_d   = 1'b1;
        bps_en_d = 1'b0;
        if (pop) begin
          shift_d  = frame[FRAME_W-1:1];
          line_d   = frame[0];
          bps_en_d = 1'b1;
          idx_d    = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (bps_clk) begin
          if (idx_q != LAST_IDX) begin
            idx_d   = idx_q + IDX_W'(1);
            line_d  = shift_q[0];
            shift_d = {1'b1, shift_q[FRAME_W-2:1]};
          end else begin
            line_d   = 1'b1;
            bps_en_d = 1'b0;
            done_d   = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
